// File: rtl/cmd_decoder_pkg.sv
// Shared definitions for the host-command decoder: opcode values, FSM state
// encodings, the per-opcode argument-count table and a saturating increment.
// Build option: CMD_DECODER_FILL_EN makes opcode 0x04 (FILL) a known command.
package cmd_decoder_pkg;

    localparam logic [7:0] OP_NOP      = 8'h00;
    localparam logic [7:0] OP_SET_ADDR = 8'h01;
    localparam logic [7:0] OP_WRITE    = 8'h02;
    localparam logic [7:0] OP_SET_REG  = 8'h03;
    localparam logic [7:0] OP_FILL     = 8'h04;

    // Pop handshake: FETCH issues the pop, LATCH presents the returned byte.
    typedef enum logic [0:0] {
        POP_FETCH = 1'b0,
        POP_LATCH = 1'b1
    } pop_state_e;

    // Parser: expecting an opcode, collecting arguments, or running a side effect.
    typedef enum logic [1:0] {
        PS_OPCODE = 2'd0,
        PS_ARGS   = 2'd1,
        PS_VRAM   = 2'd2,
        PS_REG    = 2'd3
    } parse_state_e;

    // Number of argument bytes that follow each known opcode.
    function automatic logic [1:0] arg_count(input logic [7:0] op);
        case (op)
            OP_SET_ADDR: arg_count = 2'd2;
            OP_WRITE:    arg_count = 2'd1;
            OP_SET_REG:  arg_count = 2'd2;
`ifdef CMD_DECODER_FILL_EN
            OP_FILL:     arg_count = 2'd2;
`endif
            default:     arg_count = 2'd0;
        endcase
    endfunction

    function automatic logic is_known_op(input logic [7:0] op);
        case (op)
            OP_NOP, OP_SET_ADDR, OP_WRITE, OP_SET_REG: is_known_op = 1'b1;
`ifdef CMD_DECODER_FILL_EN
            OP_FILL:                                   is_known_op = 1'b1;
`endif
            default:                                   is_known_op = 1'b0;
        endcase
    endfunction

    // 8-bit counter increment that sticks at 255.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        sat_inc8 = (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/cmd_decoder_if.sv
// Bus bundle between the command decoder and its FIFO / VRAM / register file
// neighbours. All strobes are active-low.
interface cmd_decoder_if #(
    parameter int ADDR_W = 16,
    parameter int REG_AW = 4
);
    logic              fifo_not_empty;
    logic              fifo_rd;
    logic [7:0]        fifo_rd_data;
    logic              vram_wr;
    logic              vram_ready;
    logic [ADDR_W-1:0] vram_addr;
    logic [7:0]        vram_data;
    logic              reg_wr;
    logic [REG_AW-1:0] reg_addr;
    logic [7:0]        reg_data;
    logic [7:0]        bad_op_cnt;

    modport master (
        input  fifo_not_empty, fifo_rd_data, vram_ready,
        output fifo_rd, vram_wr, vram_addr, vram_data,
               reg_wr, reg_addr, reg_data, bad_op_cnt
    );

    modport slave (
        output fifo_not_empty, fifo_rd_data, vram_ready,
        input  fifo_rd, vram_wr, vram_addr, vram_data,
               reg_wr, reg_addr, reg_data, bad_op_cnt
    );
endinterface

// File: rtl/cmd_fifo_pop.sv
// FIFO pop handshake: issues an active-low pop in FETCH when allowed and data
// is available, then in LATCH hands the returned byte to the parser with a
// one-cycle valid. Sustains at most one byte every two cycles.
module cmd_fifo_pop
    import cmd_decoder_pkg::*;
(
    input  logic       clk,
    input  logic       nrst,
    input  logic       en,
    input  logic       fifo_not_empty,
    input  logic [7:0] fifo_rd_data,
    output logic       fifo_rd,
    output logic [7:0] byte_data,
    output logic       byte_vld
);

    pop_state_e state_q, state_d;

    // State register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= POP_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Pop request is combinational and forced inactive while reset is asserted.
    always_comb begin
        state_d   = state_q;
        fifo_rd   = 1'b1;
        byte_vld  = 1'b0;
        byte_data = fifo_rd_data;
        case (state_q)
            POP_FETCH: begin
                if (nrst && en && fifo_not_empty) begin
                    fifo_rd = 1'b0;
                    state_d = POP_LATCH;
                end
            end
            POP_LATCH: begin
                byte_vld = 1'b1;
                state_d  = POP_FETCH;
            end
            default: state_d = POP_FETCH;
        endcase
    end

endmodule

// File: rtl/cmd_decoder.sv
// Host-command decoder: parses bytes popped from the command FIFO into
// SET_ADDR / WRITE / SET_REG commands, drives the VRAM write handshake and a
// one-cycle register-write strobe, and counts unknown opcodes.
// Build option: CMD_DECODER_FILL_EN enables opcode 0x04 FILL n,d.
module cmd_decoder
    import cmd_decoder_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int REG_AW = 4
) (
    input logic          clk,
    input logic          nrst,
    cmd_decoder_if.master bus
);

    parse_state_e      pstate_q, pstate_d;
    logic [7:0]        opcode_q, opcode_d;
    logic [1:0]        arg_idx_q, arg_idx_d;
    logic [7:0]        arg0_q, arg0_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        vram_data_q, vram_data_d;
    logic              vram_wr_q, vram_wr_d;
    logic              reg_wr_q, reg_wr_d;
    logic [REG_AW-1:0] reg_addr_q, reg_addr_d;
    logic [7:0]        reg_data_q, reg_data_d;
    logic [7:0]        bad_cnt_q, bad_cnt_d;
`ifdef CMD_DECODER_FILL_EN
    logic [7:0]        fill_cnt_q, fill_cnt_d;
`endif

    logic       pop_en;
    logic [7:0] byte_data;
    logic       byte_vld;
    logic [15:0] addr_full;

    // Bytes are only fetched while the parser is reading opcodes or arguments.
    assign pop_en    = (pstate_q == PS_OPCODE) || (pstate_q == PS_ARGS);
    assign addr_full = {byte_data, arg0_q};

    cmd_fifo_pop u_pop (
        .clk            (clk),
        .nrst           (nrst),
        .en             (pop_en),
        .fifo_not_empty (bus.fifo_not_empty),
        .fifo_rd_data   (bus.fifo_rd_data),
        .fifo_rd        (bus.fifo_rd),
        .byte_data      (byte_data),
        .byte_vld       (byte_vld)
    );

    // Parser, pointer and output registers; reset drops any command in flight.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            pstate_q    <= PS_OPCODE;
            opcode_q    <= OP_NOP;
            arg_idx_q   <= 2'd0;
            arg0_q      <= 8'd0;
            addr_q      <= '0;
            vram_data_q <= 8'd0;
            vram_wr_q   <= 1'b1;
            reg_wr_q    <= 1'b1;
            reg_addr_q  <= '0;
            reg_data_q  <= 8'd0;
            bad_cnt_q   <= 8'd0;
`ifdef CMD_DECODER_FILL_EN
            fill_cnt_q  <= 8'd0;
`endif
        end else begin
            pstate_q    <= pstate_d;
            opcode_q    <= opcode_d;
            arg_idx_q   <= arg_idx_d;
            arg0_q      <= arg0_d;
            addr_q      <= addr_d;
            vram_data_q <= vram_data_d;
            vram_wr_q   <= vram_wr_d;
            reg_wr_q    <= reg_wr_d;
            reg_addr_q  <= reg_addr_d;
            reg_data_q  <= reg_data_d;
            bad_cnt_q   <= bad_cnt_d;
`ifdef CMD_DECODER_FILL_EN
            fill_cnt_q  <= fill_cnt_d;
`endif
        end
    end

    // Command parsing and side-effect sequencing.
    always_comb begin
        pstate_d    = pstate_q;
        opcode_d    = opcode_q;
        arg_idx_d   = arg_idx_q;
        arg0_d      = arg0_q;
        addr_d      = addr_q;
        vram_data_d = vram_data_q;
        vram_wr_d   = vram_wr_q;
        reg_wr_d    = reg_wr_q;
        reg_addr_d  = reg_addr_q;
        reg_data_d  = reg_data_q;
        bad_cnt_d   = bad_cnt_q;
`ifdef CMD_DECODER_FILL_EN
        fill_cnt_d  = fill_cnt_q;
`endif
        case (pstate_q)
            PS_OPCODE: begin
                if (byte_vld) begin
                    opcode_d  = byte_data;
                    arg_idx_d = 2'd0;
                    if (!is_known_op(byte_data)) begin
                        bad_cnt_d = sat_inc8(bad_cnt_q);
                    end else if (arg_count(byte_data) != 2'd0) begin
                        pstate_d = PS_ARGS;
                    end
                end
            end
            PS_ARGS: begin
                if (byte_vld) begin
                    if (arg_idx_q == arg_count(opcode_q) - 2'd1) begin
                        // Final argument byte: commit the command.
                        case (opcode_q)
                            OP_SET_ADDR: begin
                                addr_d   = addr_full[ADDR_W-1:0];
                                pstate_d = PS_OPCODE;
                            end
                            OP_WRITE: begin
                                vram_data_d = byte_data;
                                vram_wr_d   = 1'b0;
                                pstate_d    = PS_VRAM;
                            end
                            OP_SET_REG: begin
                                reg_addr_d = arg0_q[REG_AW-1:0];
                                reg_data_d = byte_data;
                                reg_wr_d   = 1'b0;
                                pstate_d   = PS_REG;
                            end
`ifdef CMD_DECODER_FILL_EN
                            OP_FILL: begin
                                // A count of zero wraps through 255..1, giving 256 writes.
                                fill_cnt_d  = arg0_q;
                                vram_data_d = byte_data;
                                vram_wr_d   = 1'b0;
                                pstate_d    = PS_VRAM;
                            end
`endif
                            default: pstate_d = PS_OPCODE;
                        endcase
                    end else begin
                        arg0_d    = byte_data;
                        arg_idx_d = arg_idx_q + 2'd1;
                    end
                end
            end
            PS_VRAM: begin
                if (bus.vram_ready) begin
                    addr_d = addr_q + 1'b1;
`ifdef CMD_DECODER_FILL_EN
                    if (opcode_q == OP_FILL && fill_cnt_q != 8'd1) begin
                        fill_cnt_d = fill_cnt_q - 8'd1;
                    end else begin
                        vram_wr_d = 1'b1;
                        pstate_d  = PS_OPCODE;
                    end
`else
                    vram_wr_d = 1'b1;
                    pstate_d  = PS_OPCODE;
`endif
                end
            end
            PS_REG: begin
                reg_wr_d = 1'b1;
                pstate_d = PS_OPCODE;
            end
            default: pstate_d = PS_OPCODE;
        endcase
    end

    assign bus.vram_wr    = vram_wr_q;
    assign bus.vram_addr  = addr_q;
    assign bus.vram_data  = vram_data_q;
    assign bus.reg_wr     = reg_wr_q;
    assign bus.reg_addr   = reg_addr_q;
    assign bus.reg_data   = reg_data_q;
    assign bus.bad_op_cnt = bad_cnt_q;

endmodule

// File: tb/tb_cmd_decoder.sv
// Bench for cmd_decoder: a queue-backed FIFO model feeds command bytes, a
// stream-level parser predicts VRAM and register writes, and a negedge monitor
// records what the decoder actually does.
module tb_cmd_decoder;
    localparam int ADDR_W    = 16;
    localparam int REG_AW    = 4;
    localparam int ADDR_MASK = (1 << ADDR_W) - 1;
    localparam int REG_MASK  = (1 << REG_AW) - 1;
    localparam int BUDGET    = 20000;

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    cmd_decoder_if #(.ADDR_W(ADDR_W), .REG_AW(REG_AW)) bus ();
    cmd_decoder #(.ADDR_W(ADDR_W), .REG_AW(REG_AW)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // FIFO model and handshake environment.
    logic [7:0] fq[$];
    logic [7:0] stim[$];
    logic       pop_req = 1'b0;
    int         ready_mode = 1;   // 0 random, 1 always ready, 2 never ready
    int         pops = 0;

    // Observed and predicted transactions: vram = (addr<<8)|data, reg = (idx<<8)|val.
    int obs_vram[$], obs_reg[$], exp_vram[$], exp_reg[$];
    int m_addr = 0, m_bad = 0, m_reg_addr = 0, m_reg_data = 0;

    logic                prev_reg_low  = 1'b0;
    logic                prev_vram_low = 1'b0;
    logic                prev_acc      = 1'b0;
    logic [ADDR_W-1:0]   prev_addr     = '0;
    logic [7:0]          prev_data     = 8'd0;

    // Drive FIFO data and vram_ready just after each rising edge.
    initial forever begin
        @(posedge clk);
        #1;
        if (pop_req && fq.size() > 0) begin
            bus.fifo_rd_data = fq.pop_front();
            pops++;
        end
        bus.fifo_not_empty = (fq.size() != 0);
        case (ready_mode)
            0:       bus.vram_ready = 1'($urandom_range(0, 1));
            1:       bus.vram_ready = 1'b1;
            default: bus.vram_ready = 1'b0;
        endcase
    end

    // Observe outputs at the falling edge; they are stable there.
    initial forever begin
        @(negedge clk);
        pop_req = nrst && (bus.fifo_rd == 1'b0);
        if (nrst) begin
            if (bus.vram_wr == 1'b0 && bus.vram_ready)
                obs_vram.push_back(int'({bus.vram_addr, bus.vram_data}));
            if (bus.reg_wr == 1'b0) begin
                obs_reg.push_back(int'({bus.reg_addr, bus.reg_data}));
                check_eq("reg_wr_one_cycle", 32'(prev_reg_low), 32'd0);
            end
            if (bus.vram_wr == 1'b0)
                check_eq("no_pop_during_vram", 32'(bus.fifo_rd), 32'd1);
            if (bus.vram_wr == 1'b0 && prev_vram_low && !prev_acc) begin
                check_eq("vram_addr_stable", 32'(bus.vram_addr), 32'(prev_addr));
                check_eq("vram_data_stable", 32'(bus.vram_data), 32'(prev_data));
            end
            prev_reg_low  = (bus.reg_wr == 1'b0);
            prev_vram_low = (bus.vram_wr == 1'b0);
            prev_acc      = (bus.vram_wr == 1'b0) && bus.vram_ready;
            prev_addr     = bus.vram_addr;
            prev_data     = bus.vram_data;
        end else begin
            prev_reg_low  = 1'b0;
            prev_vram_low = 1'b0;
            prev_acc      = 1'b0;
        end
    end

    // Reference: walk the byte stream command by command and list the effects.
    task automatic model_run();
        int i, op, n;
        i = 0;
        while (i < stim.size()) begin
            op = int'(stim[i]);
            if (op == 0) begin
                i += 1;
            end else if (op == 1) begin
                if (i + 2 >= stim.size()) break;
                m_addr = ((int'(stim[i+2]) << 8) | int'(stim[i+1])) & ADDR_MASK;
                i += 3;
            end else if (op == 2) begin
                if (i + 1 >= stim.size()) break;
                exp_vram.push_back((m_addr << 8) | int'(stim[i+1]));
                m_addr = (m_addr + 1) & ADDR_MASK;
                i += 2;
            end else if (op == 3) begin
                if (i + 2 >= stim.size()) break;
                m_reg_addr = int'(stim[i+1]) & REG_MASK;
                m_reg_data = int'(stim[i+2]);
                exp_reg.push_back((m_reg_addr << 8) | m_reg_data);
                i += 3;
            end
`ifdef CMD_DECODER_FILL_EN
            else if (op == 4) begin
                if (i + 2 >= stim.size()) break;
                n = (stim[i+1] == 8'd0) ? 256 : int'(stim[i+1]);
                for (int k = 0; k < n; k++) begin
                    exp_vram.push_back((m_addr << 8) | int'(stim[i+2]));
                    m_addr = (m_addr + 1) & ADDR_MASK;
                end
                i += 3;
            end
`endif
            else begin
                if (m_bad < 255) m_bad++;
                i += 1;
            end
        end
        foreach (stim[k]) fq.push_back(stim[k]);
    endtask

    task automatic wait_idle(input string name);
        int cyc;
        cyc = 0;
        while ((fq.size() != 0 || obs_vram.size() < exp_vram.size() ||
                obs_reg.size() < exp_reg.size() || bus.vram_wr == 1'b0) && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
        end
        repeat (6) @(negedge clk);
        check_eq({name, "_done_in_budget"}, 32'(cyc < BUDGET), 32'd1);
    endtask

    task automatic compare_all(input string name);
        int n;
        check_eq({name, "_vram_count"}, 32'(obs_vram.size()), 32'(exp_vram.size()));
        check_eq({name, "_reg_count"},  32'(obs_reg.size()),  32'(exp_reg.size()));
        n = (obs_vram.size() < exp_vram.size()) ? obs_vram.size() : exp_vram.size();
        for (int k = 0; k < n; k++) check_eq({name, "_vram_wr"}, 32'(obs_vram[k]), 32'(exp_vram[k]));
        n = (obs_reg.size() < exp_reg.size()) ? obs_reg.size() : exp_reg.size();
        for (int k = 0; k < n; k++) check_eq({name, "_reg_wr"}, 32'(obs_reg[k]), 32'(exp_reg[k]));
        check_eq({name, "_vram_addr"}, 32'(bus.vram_addr), 32'(m_addr));
        check_eq({name, "_bad_cnt"},   32'(bus.bad_op_cnt), 32'(m_bad));
        check_eq({name, "_reg_addr"},  32'(bus.reg_addr), 32'(m_reg_addr));
        check_eq({name, "_reg_data"},  32'(bus.reg_data), 32'(m_reg_data));
        obs_vram.delete(); exp_vram.delete(); obs_reg.delete(); exp_reg.delete();
    endtask

    task automatic check_reset(input string name);
        check_eq({name, "_fifo_rd"},  32'(bus.fifo_rd), 32'd1);
        check_eq({name, "_vram_wr"},  32'(bus.vram_wr), 32'd1);
        check_eq({name, "_reg_wr"},   32'(bus.reg_wr), 32'd1);
        check_eq({name, "_vram_addr"}, 32'(bus.vram_addr), 32'd0);
        check_eq({name, "_vram_data"}, 32'(bus.vram_data), 32'd0);
        check_eq({name, "_reg_addr"}, 32'(bus.reg_addr), 32'd0);
        check_eq({name, "_reg_data"}, 32'(bus.reg_data), 32'd0);
        check_eq({name, "_bad_cnt"},  32'(bus.bad_op_cnt), 32'd0);
    endtask

    task automatic async_reset();
        nrst = 1'b0;
        fq.delete();
        bus.fifo_not_empty = 1'b0;
        pop_req = 1'b0;
        m_addr = 0; m_bad = 0; m_reg_addr = 0; m_reg_data = 0;
        obs_vram.delete(); exp_vram.delete(); obs_reg.delete(); exp_reg.delete();
    endtask

    initial begin
        int p0, cyc, kind;
        logic [ADDR_W-1:0] a_snap;
        logic [7:0]        d_snap;
        bus.fifo_not_empty = 1'b0;
        bus.fifo_rd_data   = 8'd0;
        bus.vram_ready     = 1'b0;

        // Power-on reset values.
        repeat (3) @(negedge clk);
        check_reset("por");
        nrst = 1'b1;

        // Address set then one write.
        stim = '{8'h01, 8'h34, 8'h12, 8'h02, 8'hAB};
        model_run();
        wait_idle("t1");
        if (obs_vram.size() > 0) check_eq("t1_write", 32'(obs_vram[0]), 32'h1234AB);
        check_eq("t1_addr_after", 32'(bus.vram_addr), 32'h1235);
        compare_all("t1");

        // Register write strobe.
        stim = '{8'h03, 8'h07, 8'h5A};
        model_run();
        wait_idle("t2");
        check_eq("t2_reg_addr", 32'(bus.reg_addr), 32'h7);
        check_eq("t2_reg_data", 32'(bus.reg_data), 32'h5A);
        compare_all("t2");

        // Address wrap at the top of VRAM, with random ready.
        ready_mode = 0;
        stim = '{8'h01, 8'hFF, 8'hFF, 8'h02, 8'h11, 8'h02, 8'h22};
        model_run();
        wait_idle("t3");
        if (obs_vram.size() > 1) begin
            check_eq("t3_write0", 32'(obs_vram[0]), 32'hFFFF11);
            check_eq("t3_write1", 32'(obs_vram[1]), 32'h000022);
        end
        compare_all("t3");

        // Saturating unknown-opcode counter; FIFO drains fully.
        ready_mode = 1;
        stim.delete();
        for (int k = 0; k < 300; k++) stim.push_back(8'hEE);
        p0 = pops;
        model_run();
        wait_idle("t5");
        check_eq("t5_bad_sat", 32'(bus.bad_op_cnt), 32'd255);
        check_eq("t5_popped", 32'(pops - p0), 32'd300);
        check_eq("t5_fifo_empty", 32'(fq.size()), 32'd0);
        compare_all("t5");

        // Reset while a SET_ADDR is half-parsed.
        stim = '{8'h01, 8'h34};
        foreach (stim[k]) fq.push_back(stim[k]);
        p0 = pops; cyc = 0;
        while (pops < p0 + 2 && cyc < 100) begin @(negedge clk); cyc++; end
        check_eq("t6a_popped", 32'(pops - p0), 32'd2);
        #2 async_reset();
        #1 check_reset("t6a");
        repeat (2) @(negedge clk);
        nrst = 1'b1;

        // VRAM request stalled by ready low: held, stable, no pops.
        ready_mode = 2;
        stim = '{8'h01, 8'h00, 8'h40, 8'h02, 8'h55, 8'h00, 8'h00};
        model_run();
        cyc = 0;
        while (bus.vram_wr !== 1'b0 && cyc < 100) begin @(negedge clk); cyc++; end
        check_eq("t4_vram_req", 32'(bus.vram_wr), 32'd0);
        p0 = pops; a_snap = bus.vram_addr; d_snap = bus.vram_data;
        check_eq("t4_addr", 32'(a_snap), 32'h4000);
        check_eq("t4_data", 32'(d_snap), 32'h55);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check_eq("t4_held", 32'(bus.vram_wr), 32'd0);
            check_eq("t4_addr_hold", 32'(bus.vram_addr), 32'(a_snap));
        end
        check_eq("t4_no_pops", 32'(pops - p0), 32'd0);
        ready_mode = 1;
        wait_idle("t4");
        compare_all("t4");

        // Reset while a VRAM request is pending.
        ready_mode = 2;
        stim = '{8'h02, 8'h99};
        foreach (stim[k]) fq.push_back(stim[k]);
        cyc = 0;
        while (bus.vram_wr !== 1'b0 && cyc < 100) begin @(negedge clk); cyc++; end
        check_eq("t6b_vram_req", 32'(bus.vram_wr), 32'd0);
        #2 async_reset();
        #1 check_reset("t6b");
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        ready_mode = 1;

`ifdef CMD_DECODER_FILL_EN
        // FILL: three writes of the same byte.
        stim = '{8'h01, 8'h10, 8'h00, 8'h04, 8'h03, 8'h5C};
        model_run();
        wait_idle("fill");
        check_eq("fill_count", 32'(obs_vram.size()), 32'd3);
        if (obs_vram.size() > 2) begin
            check_eq("fill_w0", 32'(obs_vram[0]), 32'h00105C);
            check_eq("fill_w1", 32'(obs_vram[1]), 32'h00115C);
            check_eq("fill_w2", 32'(obs_vram[2]), 32'h00125C);
        end
        compare_all("fill");
`endif

        // Random command mix with random ready.
        ready_mode = 0;
        stim.delete();
        for (int c = 0; c < 80; c++) begin
            kind = int'($urandom_range(0, 5));
            case (kind)
                0: stim.push_back(8'h00);
                1: begin
                    stim.push_back(8'h01);
                    stim.push_back(8'($urandom));
                    stim.push_back(($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom));
                end
                2: begin stim.push_back(8'h02); stim.push_back(8'($urandom)); end
                3: begin
                    stim.push_back(8'h03);
                    stim.push_back(8'($urandom));
                    stim.push_back(8'($urandom));
                end
                4: begin
                    stim.push_back(8'h04);
                    stim.push_back(8'($urandom_range(0, 4)));
                    stim.push_back(8'($urandom));
                end
                default: stim.push_back(8'($urandom_range(5, 255)));
            endcase
        end
        stim.push_back(8'h00);
        stim.push_back(8'h00);
        model_run();
        wait_idle("rand");
        compare_all("rand");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
